nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 20 ++
 rtl/nibble_serial_adder_cla4_slice.sv | 35 +++
 rtl/nibble_serial_adder.sv | 165 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t     : FSM state encoding (IDLE / RUN / DONE)
//   NIB_W       : width of one nibble step (4 bits)
//   cnt_width() : bit width of the nibble counter for a given step count
package nibble_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIB_W = 4;

   // Counter must be at least one bit wide even for a single step.
   function automatic int cnt_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// cla4_slice: purely combinational 4-bit carry-lookahead adder.
// Ports:
//   A, B  : 4-bit addends
//   cin   : carry-in
//   S     : 4-bit sum
//   cout  : carry-out of bit 3
module cla4_slice (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       cin,
   output logic [3:0] S,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = A & B;
   assign p = A ^ B;

   // Every carry is computed directly from generate/propagate terms and cin,
   // so no carry ripples from one bit to the next.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign S    = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder that pushes one nibble per
// clock through a single cla4_slice. A start accepted in IDLE or DONE captures
// the operands; WIDTH/4 RUN cycles follow, then a one-cycle DONE pulse.
// Optional feature macro: NIBBLE_SERIAL_ADDER_ADDSUB_EN (adds port sub; when
// sub=1 the result is a - b and cout=1 means no borrow).
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, sampled only in IDLE or DONE
//   a, b  : WIDTH-bit operands, captured on accepted start
//   cin   : carry-in, captured on accepted start
//   sub   : (macro only) subtract select, captured on accepted start
//   busy  : high while in RUN
//   done  : one-cycle pulse, result valid
//   sum   : registered WIDTH-bit result
//   cout  : registered carry-out of the MSB nibble
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIB = WIDTH / NIB_W;
   localparam int CW  = cnt_width(NIB);

   state_t           state;
   state_t           state_next;
   logic             load;
   logic             step;
   logic             last;

   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;

   logic [WIDTH-1:0] b_eff;
   logic             carry_init;
   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic [3:0]       slice_s;
   logic             slice_cout;

`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
   logic sub_reg;

   // Subtraction is a + ~b + 1: invert every b nibble and force the initial carry.
   assign b_eff      = b_reg ^ {WIDTH{sub_reg}};
   assign carry_init = sub ? 1'b1 : cin;
`else
   assign b_eff      = b_reg;
   assign carry_init = cin;
`endif

   assign last = (counter == CW'(NIB - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            // A start here begins the next operation with no idle gap.
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- nibble select ----------------
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < NIB; i++) begin
         if (counter == CW'(i)) begin
            slice_a = a_reg[i*NIB_W +: NIB_W];
            slice_b = b_eff[i*NIB_W +: NIB_W];
         end
      end
   end

   cla4_slice u_slice (
      .A    (slice_a),
      .B    (slice_b),
      .cin  (carry_reg),
      .S    (slice_s),
      .cout (slice_cout)
   );

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         counter   <= '0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
         sub_reg   <= 1'b0;
`endif
      end else if (load) begin
         a_reg     <= a;
         b_reg     <= b;
         counter   <= '0;
         carry_reg <= carry_init;
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
         sub_reg   <= sub;
`endif
      end else if (step) begin
         // Only the current nibble of sum is written; the others keep old data.
         for (int i = 0; i < NIB; i++) begin
            if (counter == CW'(i)) sum_reg[i*NIB_W +: NIB_W] <= slice_s;
         end
         carry_reg <= slice_cout;
         counter   <= counter + 1'b1;
         if (last) cout_reg <= slice_cout;
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;

   int n_compared   = 0;
   int n_mismatched = 0;
   int done_count   = 0;
   logic        prev_done = 1'b0;
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_compared++;
      assert (obs === expv) else begin
         n_mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Scoreboard side: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         done_count++;
         check("done_pulse_width", {31'b0, prev_done}, 32'd0);
         if (exp_q.size() == 0) begin
            check("done_without_request", {31'b0, done}, 32'd0);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("sum", {16'b0, sum}, {16'b0, e[15:0]});
            check("cout", {31'b0, cout}, {31'b0, e[16]});
         end
      end
      prev_done = rst ? 1'b0 : done;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed time limit reached expected finish");
      $fatal(1, "timeout");
   end

   // Drive a start for one accepted edge; returns 1 time unit after that edge.
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                        input logic is, input bit push);
      logic [16:0] e;
      start = 1'b1; a = ia; b = ib; cin = ic; sub = is;
      if (is
`ifndef NIBBLE_SERIAL_ADDER_ADDSUB_EN
          && 1'b0
`endif
         ) e = {1'b0, ia} + {1'b0, ~ib} + 17'd1;
      else
         e = {1'b0, ia} + {1'b0, ib} + {16'b0, ic};
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
   endtask

   // Returns at negedge+1 of the cycle in which a new done was seen.
   task automatic wait_done(input int prev, input int max_cycles, input string tag);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         #1;
         if (done_count > prev) return;
      end
      check({tag, "_timeout"}, done_count, prev + 1);
   endtask

   initial begin
      int prev;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #2;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_sum", {16'b0, sum}, 32'd0);
      check("reset_cout", {31'b0, cout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic add, latency and busy window.
      prev = done_count;
      issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_busy_run", {31'b0, busy}, 32'd1);
         check("t1_no_done_in_run", {31'b0, done}, 32'd0);
      end
      @(negedge clk);
      check("t1_done_at_latency", {31'b0, done}, 32'd1);
      check("t1_busy_in_done", {31'b0, busy}, 32'd0);
      #1;
      check("t1_done_count", done_count, prev + 1);
      check("t1_sum_5555", {16'b0, sum}, 32'h5555);

      // Carry through every nibble.
      @(negedge clk);
      prev = done_count;
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
      wait_done(prev, 20, "t2");

      // Carry-in, then back-to-back start held in the DONE cycle.
      @(negedge clk);
      prev = done_count;
      issue(16'h8000, 16'h8000, 1'b1, 1'b0, 1);
      wait_done(prev, 20, "t3a");
      check("t3_done_high", {31'b0, done}, 32'd1);
      issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1);
      check("t3_back_to_back_busy", {31'b0, busy}, 32'd1);
      wait_done(prev + 1, 20, "t3b");
      repeat (3) @(negedge clk);
      check("t3_idle_sum_hold", {16'b0, sum}, 32'h1000);
      check("t3_idle_cout_hold", {31'b0, cout}, 32'd0);
      check("t3_idle_busy", {31'b0, busy}, 32'd0);

      // start during RUN is ignored.
      prev = done_count;
      issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1);
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(prev, 20, "t4");
      repeat (8) @(negedge clk);
      check("t4_single_done", done_count, prev + 1);

      // Reset in the middle of an operation.
      @(negedge clk);
      prev = done_count;
      issue(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t5_rst_sum", {16'b0, sum}, 32'd0);
      check("t5_rst_cout", {31'b0, cout}, 32'd0);
      check("t5_rst_busy", {31'b0, busy}, 32'd0);
      check("t5_rst_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("t5_no_done_after_abort", done_count, prev);
      prev = done_count;
      issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1);
      wait_done(prev, 20, "t5");
      check("t5_sum_0002", {16'b0, sum}, 32'h0002);

`ifdef NIBBLE_SERIAL_ADDER_ADDSUB_EN
      @(negedge clk);
      prev = done_count;
      issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
      wait_done(prev, 20, "t6a");
      check("t6_sub_borrow_sum", {16'b0, sum}, 32'hFFFE);
      prev = done_count;
      issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1);
      wait_done(prev, 20, "t6b");
      check("t6_sub_noborrow_cout", {31'b0, cout}, 32'd1);
`endif

      // A few random operations, scoreboard-checked.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         prev = done_count;
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
         wait_done(prev, 20, "rand");
      end

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
